// File: rtl/ex_pipe_pkg.sv
// ex_pipe_pkg: control-word and entry types shared by the ID->EX stage register.
// Rev 1.0
`default_nettype none

package ex_pipe_pkg;

  typedef struct packed {
    logic [4:0] alu_op;
    logic       link;
    logic       alu_src_imm;
    logic       trap;
    logic       trap_cond;
    logic       reg_dst;
    logic       llsc;
    logic       mem_read;
    logic       mem_write;
    logic       mem_half;
    logic       mem_byte;
    logic       mem_sign_extend;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam int CTRL_W      = $bits(ctrl_t);
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_OPS = 3;

  // Entry layout for the default datapath; the top packs the same field order generically.
  typedef struct packed {
    ctrl_t                                ctrl;
    logic [4:0]                           rd;
    logic [4:0]                           shamt;
    logic [DEF_NUM_OPS*DEF_DATA_W-1:0]    ops;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/elastic_buf.sv
// elastic_buf: DEPTH-entry circular buffer with explicit occupancy count and flush.
// Rev 1.0
`default_nettype none

module elastic_buf #(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [OCC_W-1:0] count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (push && !pop) begin
        r_count <= r_count + OCC_W'(1);
      end else if (pop && !push) begin
        r_count <= r_count - OCC_W'(1);
      end
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ex_stage_elastic_reg.sv
// ex_stage_elastic_reg: ID->EX elastic stage register with flush, legacy stall and stall counter.
// Rev 1.0
`default_nettype none

module ex_stage_elastic_reg #(
  parameter  int CTRL_W  = ex_pipe_pkg::CTRL_W,
  parameter  int DATA_W  = 32,
  parameter  int NUM_OPS = 3,
  parameter  int DEPTH   = 2,
  parameter  int CNT_W   = 16,
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      stall,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [4:0]                in_rd,
  input  logic [4:0]                in_shamt,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [4:0]                out_rd,
  output logic [4:0]                out_shamt,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [OCC_W-1:0]          occupancy,
  output logic [CNT_W-1:0]          stall_cnt
);

  import ex_pipe_pkg::*;

  localparam int ENT_W = CTRL_W + 10 + NUM_OPS * DATA_W;

  logic             w_enq;
  logic             w_deq;
  logic             w_blocked;
  logic [ENT_W-1:0] w_din;
  logic [ENT_W-1:0] w_dout;
  logic [CTRL_W-1:0] w_head_ctrl;
  logic [OCC_W-1:0] w_count;
  logic [CNT_W-1:0] r_stall_cnt;

  // in_ready looks only at the held count, so a full buffer never accepts even while draining.
  assign in_ready  = (w_count < OCC_W'(DEPTH));
  assign out_valid = (w_count != '0);
  assign w_enq     = in_valid & in_ready & ~flush;
  assign w_deq     = out_valid & out_ready & ~stall & ~flush;
  assign w_blocked = out_valid & (~out_ready | stall) & ~flush;

  assign w_din = {in_ctrl, in_rd, in_shamt, in_ops};

  elastic_buf #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (w_enq),
    .pop   (w_deq),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count)
  );

  assign {w_head_ctrl, out_rd, out_shamt, out_ops} = w_dout;

  // Bubbles carry an all-zero control word so no stale write/trap enable leaks into EX.
  assign out_ctrl  = out_valid ? w_head_ctrl : '0;
  assign occupancy = w_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_blocked && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_elastic_reg.sv
// tb_ex_stage_elastic_reg: table vectors, directed corner sequences and random traffic vs a queue model.
// Rev 1.0
`default_nettype none

module tb_ex_stage_elastic_reg;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [17:0] ctrl;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [95:0] ops;
  } ent_t;

  typedef struct {
    bit         iv;
    bit         ordy;
    bit         stl;
    bit         fl;
    logic [7:0] tag;
    bit         ev;
    int         eocc;
    bit         erdy;
    int         escnt;
    logic [7:0] ehead;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] in_ctrl = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_shamt = '0;
  logic [95:0] in_ops = '0;

  logic        in_ready, out_valid;
  logic [17:0] out_ctrl;
  logic [4:0]  out_rd, out_shamt;
  logic [95:0] out_ops;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        in_ready_b, out_valid_b;
  logic [17:0] out_ctrl_b;
  logic [4:0]  out_rd_b, out_shamt_b;
  logic [95:0] out_ops_b;
  logic [1:0]  occupancy_b;
  logic [3:0]  stall_cnt_b;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  int   m_scnt = 0;
  vec_t tbl[21];

  always #5 clk = ~clk;

  ex_stage_elastic_reg #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_ops(in_ops), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_shamt(out_shamt), .out_ops(out_ops),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  ex_stage_elastic_reg #(.DEPTH(DEPTH), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_ctrl(in_ctrl), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_ops(in_ops), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_ctrl(out_ctrl_b), .out_rd(out_rd_b), .out_shamt(out_shamt_b), .out_ops(out_ops_b),
    .occupancy(occupancy_b), .stall_cnt(stall_cnt_b)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t from_tag(input logic [7:0] tag);
    ent_t e;
    e.ctrl  = 18'h3FFFF;
    e.rd    = tag[4:0];
    e.shamt = ~tag[4:0];
    e.ops   = {32'(tag) + 32'd2, 32'(tag) + 32'd1, 32'(tag)};
    return e;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.ctrl  = 18'($urandom);
    e.rd    = 5'($urandom);
    e.shamt = 5'($urandom);
    e.ops   = {$urandom, $urandom, $urandom};
    return e;
  endfunction

  function automatic vec_t mk(bit iv, bit ordy, bit stl, bit fl, logic [7:0] tag,
                              bit ev, int eocc, bit erdy, int escnt, logic [7:0] ehead);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.stl = stl; v.fl = fl; v.tag = tag;
    v.ev = ev; v.eocc = eocc; v.erdy = erdy; v.escnt = escnt; v.ehead = ehead;
    return v;
  endfunction

  // Compare both instances against the queue model's view of the current state.
  task automatic check_model();
    int sz = q.size();
    int sat16 = (m_scnt > 65535) ? 65535 : m_scnt;
    int sat4  = (m_scnt > 15) ? 15 : m_scnt;
    chk("out_valid", out_valid, sz != 0);
    chk("in_ready", in_ready, sz < DEPTH);
    chk("occupancy", occupancy, sz);
    chk("occupancy_b", occupancy_b, sz);
    chk("stall_cnt", stall_cnt, sat16);
    chk("stall_cnt_sat4", stall_cnt_b, sat4);
    if (sz != 0) begin
      chk("out_ctrl", out_ctrl, q[0].ctrl);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_shamt", out_shamt, q[0].shamt);
      chk("out_ops", out_ops, q[0].ops);
    end else begin
      chk("out_ctrl_bubble", out_ctrl, 0);
      chk("out_ctrl_bubble_b", out_ctrl_b, 0);
    end
  endtask

  task automatic model_edge(input bit iv, input bit ordy, input bit stl, input bit fl, input ent_t e);
    int sz = q.size();
    bit deq = (sz != 0) && ordy && !stl && !fl;
    bit enq = iv && (sz < DEPTH) && !fl;
    if ((sz != 0) && (!ordy || stl) && !fl) m_scnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (deq) void'(q.pop_front());
      if (enq) q.push_back(e);
    end
  endtask

  // One cycle: entered and left on a falling edge.
  task automatic cyc(input bit iv, input bit ordy, input bit stl, input bit fl, input ent_t e);
    check_model();
    in_valid  = iv;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
    in_ctrl   = e.ctrl;
    in_rd     = e.rd;
    in_shamt  = e.shamt;
    in_ops    = e.ops;
    @(posedge clk);
    model_edge(iv, ordy, stl, fl, e);
    @(negedge clk);
  endtask

  initial begin
    // Backpressure, stall hold, flush while full, flush of lone input, enq+deq together.
    tbl[0]  = mk(1, 0, 0, 0, 8'h11, 1, 1, 1, 0, 8'h11);
    tbl[1]  = mk(1, 0, 0, 0, 8'h12, 1, 2, 0, 1, 8'h11);
    tbl[2]  = mk(1, 0, 0, 0, 8'h13, 1, 2, 0, 2, 8'h11);
    tbl[3]  = mk(0, 1, 0, 0, 8'h00, 1, 1, 1, 2, 8'h12);
    tbl[4]  = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 2, 8'h00);
    tbl[5]  = mk(1, 1, 1, 0, 8'h21, 1, 1, 1, 2, 8'h21);
    tbl[6]  = mk(0, 1, 1, 0, 8'h00, 1, 1, 1, 3, 8'h21);
    tbl[7]  = mk(0, 1, 1, 0, 8'h00, 1, 1, 1, 4, 8'h21);
    tbl[8]  = mk(0, 1, 1, 0, 8'h00, 1, 1, 1, 5, 8'h21);
    tbl[9]  = mk(0, 1, 1, 0, 8'h00, 1, 1, 1, 6, 8'h21);
    tbl[10] = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 6, 8'h00);
    tbl[11] = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 6, 8'h00);
    tbl[12] = mk(1, 0, 0, 0, 8'h31, 1, 1, 1, 6, 8'h31);
    tbl[13] = mk(1, 0, 0, 0, 8'h32, 1, 2, 0, 7, 8'h31);
    tbl[14] = mk(1, 0, 0, 1, 8'h33, 0, 0, 1, 7, 8'h00);
    tbl[15] = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 7, 8'h00);
    tbl[16] = mk(1, 1, 0, 1, 8'h41, 0, 0, 1, 7, 8'h00);
    tbl[17] = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 7, 8'h00);
    tbl[18] = mk(1, 1, 0, 0, 8'h51, 1, 1, 1, 7, 8'h51);
    tbl[19] = mk(1, 1, 0, 0, 8'h52, 1, 1, 1, 7, 8'h52);
    tbl[20] = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 7, 8'h00);

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0 + 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_out_ops", out_ops, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].iv, tbl[i].ordy, tbl[i].stl, tbl[i].fl, from_tag(tbl[i].tag));
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].eocc);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].erdy);
      chk($sformatf("tbl%0d_scnt", i), stall_cnt, tbl[i].escnt);
      chk($sformatf("tbl%0d_ctrl", i), out_ctrl, tbl[i].ev ? 18'h3FFFF : 18'h0);
      if (tbl[i].ev) chk($sformatf("tbl%0d_head", i), out_ops[7:0], tbl[i].ehead);
    end

    // Streaming: each input appears on the output right after the edge that took it.
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 1, 0, 0, from_tag(8'(k)));
      chk($sformatf("stream%0d_op0", k), out_ops[31:0], k);
      chk($sformatf("stream%0d_ready", k), in_ready, 1);
      chk($sformatf("stream%0d_scnt", k), stall_cnt, 7);
    end
    cyc(0, 1, 0, 0, from_tag(8'h00));
    chk("stream_drained", out_valid, 0);

    // Asynchronous reset with two entries held.
    cyc(1, 0, 0, 0, from_tag(8'h61));
    cyc(1, 0, 0, 0, from_tag(8'h62));
    chk("pre_rst_occ", occupancy, 2);
    in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_occ", occupancy, 0);
    chk("async_rst_ctrl", out_ctrl, 0);
    chk("async_rst_scnt", stall_cnt, 0);
    #2 rst_n = 1'b1;
    q.delete();
    m_scnt = 0;
    @(negedge clk);

    // Saturation: hold the head blocked for 20 cycles.
    cyc(1, 0, 0, 0, from_tag(8'h71));
    repeat (20) cyc(0, 0, 0, 0, from_tag(8'h00));
    chk("sat_cnt4", stall_cnt_b, 15);
    chk("sat_cnt16", stall_cnt, 20);
    cyc(0, 0, 0, 1, from_tag(8'h00));

    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) < 3, $urandom_range(0, 19) == 0, rand_ent());
    end
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
